fetch_stage: RTL

FETCH_STAGE -- requirements
Module: fetch_stage

---
 rtl/fetch_stage.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/fetch_stage.sv
// Instruction fetch stage: issues one imem request at a time, buffers a
// response that arrives while decode is stalled, and drives the IF/ID register.
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'hBFC00000,
    parameter logic [31:0] NOP      = 32'h00000013
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall_i,
    input  logic [1:0]  PCSrc,
    input  logic [31:0] pc_target_i,
    input  logic [31:0] alu_result_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_rvalid_i,
    input  logic [31:0] imem_rdata_i,
    output logic [31:0] instr_o,
    output logic [31:0] pc_o,
    output logic [31:0] pc_plus4_o,
    output logic        valid_o,
    output logic [6:0]  op_o,
    output logic [2:0]  funct3_o,
    output logic        funct7_o
);

    typedef enum logic [1:0] {StReq, StWait, StHold, StDrop} state_e;

    state_e      state_q, state_d;
    logic [31:0] fetch_pc_q, fetch_pc_d;
    logic [31:0] skid_q, skid_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] pc_q, pc_d;
    logic        valid_q, valid_d;

    logic        redirect;
    logic [31:0] redirect_pc;
    logic        if_load;
    logic [31:0] if_load_data;

    // Redirect only acts on a real instruction that decode is consuming.
    always_comb begin
        redirect    = valid_q && !stall_i && ((PCSrc == 2'b01) || (PCSrc == 2'b10));
        redirect_pc = (PCSrc == 2'b10) ? (alu_result_i & 32'hFFFF_FFFE) : pc_target_i;
    end

    // Next-state, imem request and IF/ID load selection.
    always_comb begin
        state_d      = state_q;
        skid_d       = skid_q;
        imem_req_o   = 1'b0;
        imem_addr_o  = fetch_pc_q;
        if_load      = 1'b0;
        if_load_data = imem_rdata_i;

        unique case (state_q)
            StReq: begin
                imem_req_o = 1'b1;
                // A redirect here leaves the request just issued outstanding.
                state_d    = redirect ? StDrop : StWait;
            end
            StWait: begin
                if (redirect) begin
                    state_d = imem_rvalid_i ? StReq : StDrop;
                end else if (imem_rvalid_i) begin
                    if (stall_i) begin
                        skid_d  = imem_rdata_i;
                        state_d = StHold;
                    end else begin
                        if_load      = 1'b1;
                        if_load_data = imem_rdata_i;
                        state_d      = StReq;
                    end
                end
            end
            StHold: begin
                if (redirect) begin
                    skid_d  = '0;
                    state_d = StReq;
                end else if (!stall_i) begin
                    if_load      = 1'b1;
                    if_load_data = skid_q;
                    skid_d       = '0;
                    state_d      = StReq;
                end
            end
            StDrop: begin
                if (imem_rvalid_i) begin
                    state_d = StReq;
                end
            end
            default: state_d = StReq;
        endcase
    end

    // IF/ID register and fetch PC update.
    always_comb begin
        fetch_pc_d = fetch_pc_q;
        instr_d    = instr_q;
        pc_d       = pc_q;
        valid_d    = valid_q;

        if (redirect) begin
            fetch_pc_d = redirect_pc;
            valid_d    = 1'b0;
            instr_d    = NOP;
        end else if (if_load) begin
            instr_d    = if_load_data;
            pc_d       = fetch_pc_q;
            valid_d    = 1'b1;
            fetch_pc_d = fetch_pc_q + 32'd4;
        end else if (!stall_i) begin
            // Decode consumed or had nothing; present a bubble.
            valid_d = 1'b0;
            instr_d = NOP;
        end
    end

    // State registers with asynchronous reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StReq;
            fetch_pc_q <= RESET_PC;
            skid_q     <= '0;
            instr_q    <= NOP;
            pc_q       <= '0;
            valid_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            skid_q     <= skid_d;
            instr_q    <= instr_d;
            pc_q       <= pc_d;
            valid_q    <= valid_d;
        end
    end

    assign instr_o    = instr_q;
    assign pc_o       = pc_q;
    assign pc_plus4_o = pc_q + 32'd4;
    assign valid_o    = valid_q;
    assign op_o       = instr_q[6:0];
    assign funct3_o   = instr_q[14:12];
    assign funct7_o   = instr_q[30];

endmodule
